// File: rtl/fifoc_pkg.sv
// Shared defaults and address helpers for the multi-channel FIFO controller.
package fifoc_pkg;
  localparam int DEF_NCH     = 4;
  localparam int DEF_CHBIT   = 2;
  localparam int DEF_LENGTH  = 16;
  localparam int DEF_ADDRBIT = 4;
  localparam int DEF_MEMABIT = 6;
  localparam int DEF_AFTHR   = 12;

  // Wrap at length-1 so non-power-of-2 depths work.
  function automatic int ptr_inc(input int ptr, input int length);
    return (ptr == length - 1) ? 0 : ptr + 1;
  endfunction

  function automatic int ch_base(input int ch, input int length);
    return ch * length;
  endfunction
endpackage

// File: rtl/fifoc_chslice.sv
// One channel's pointers, occupancy, sticky flags and (with FIFOC_HWM_EN) high-water mark.
// Accept is same-cycle from registered state; rejected requests only raise ovf/udf.
module fifoc_chslice
  import fifoc_pkg::*;
#(
  parameter int LENGTH  = DEF_LENGTH,
  parameter int ADDRBIT = DEF_ADDRBIT,
  parameter int AFTHR   = DEF_AFTHR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_hit,
  input  logic               rd_hit,
  input  logic               fsh_hit,
  output logic               wr_acc,
  output logic               rd_acc,
  output logic [ADDRBIT-1:0] wrptr,
  output logic [ADDRBIT-1:0] rdptr,
  output logic [ADDRBIT:0]   len,
  output logic [ADDRBIT:0]   hwm,
  output logic               notempty,
  output logic               full,
  output logic               afull,
  output logic               ovf,
  output logic               udf
);
  localparam logic [ADDRBIT:0] LEN_FULL = (ADDRBIT+1)'(LENGTH);
  localparam logic [ADDRBIT:0] LEN_AF   = (ADDRBIT+1)'(AFTHR);

  logic [ADDRBIT:0] len_next;

  assign notempty = (len != '0);
  assign full     = (len == LEN_FULL);
  assign afull    = (len >= LEN_AF);
  assign wr_acc   = wr_hit & ~full & ~fsh_hit;
  assign rd_acc   = rd_hit & notempty & ~fsh_hit;

  always_comb begin
    len_next = len;
    if (fsh_hit)
      len_next = '0;
    else if (wr_acc && !rd_acc)
      len_next = len + 1'b1;
    else if (rd_acc && !wr_acc)
      len_next = len - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || fsh_hit) begin
      wrptr <= '0;
      rdptr <= '0;
      len   <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_acc) wrptr <= ADDRBIT'(ptr_inc(int'(wrptr), LENGTH));
      if (rd_acc) rdptr <= ADDRBIT'(ptr_inc(int'(rdptr), LENGTH));
      len <= len_next;
      if (wr_hit && full)      ovf <= 1'b1;
      if (rd_hit && !notempty) udf <= 1'b1;
    end
  end

`ifdef FIFOC_HWM_EN
  always_ff @(posedge clk) begin
    if (rst || fsh_hit)
      hwm <= '0;
    else if (len_next > hwm)
      hwm <= len_next;
  end
`else
  assign hwm = '0;
`endif
endmodule

// File: rtl/fifoc_anylen_mch.sv
// NCH any-length FIFOs in one shared memory; high-water mark optional via FIFOC_HWM_EN.
// Zero-latency memory strobes; writes to full / reads of empty channels are dropped and flagged.
module fifoc_anylen_mch
  import fifoc_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int CHBIT   = DEF_CHBIT,
  parameter int LENGTH  = DEF_LENGTH,
  parameter int ADDRBIT = DEF_ADDRBIT,
  parameter int MEMABIT = DEF_MEMABIT,
  parameter int AFTHR   = DEF_AFTHR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [CHBIT-1:0]   wr_ch,
  input  logic               rd_en,
  input  logic [CHBIT-1:0]   rd_ch,
  input  logic               fsh_en,
  input  logic [CHBIT-1:0]   fsh_ch,
  input  logic [CHBIT-1:0]   qry_ch,
  output logic [ADDRBIT:0]   qry_len,
  output logic [ADDRBIT:0]   qry_hwm,
  output logic [NCH-1:0]     notempty,
  output logic [NCH-1:0]     full,
  output logic [NCH-1:0]     afull,
  output logic [NCH-1:0]     ovf,
  output logic [NCH-1:0]     udf,
  output logic               mem_we,
  output logic [MEMABIT-1:0] mem_wa,
  output logic               mem_re,
  output logic [MEMABIT-1:0] mem_ra
);
  logic [NCH-1:0]     wr_acc, rd_acc;
  logic [ADDRBIT-1:0] wrptr [NCH];
  logic [ADDRBIT-1:0] rdptr [NCH];
  logic [ADDRBIT:0]   len   [NCH];
  logic [ADDRBIT:0]   hwm   [NCH];
  logic [ADDRBIT-1:0] wsel, rsel;

  // Channel indices >= NCH never match a slice, so they decode to no-ops.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    fifoc_chslice #(
      .LENGTH  (LENGTH),
      .ADDRBIT (ADDRBIT),
      .AFTHR   (AFTHR)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .wr_hit   (wr_en  && (wr_ch  == CHBIT'(c))),
      .rd_hit   (rd_en  && (rd_ch  == CHBIT'(c))),
      .fsh_hit  (fsh_en && (fsh_ch == CHBIT'(c))),
      .wr_acc   (wr_acc[c]),
      .rd_acc   (rd_acc[c]),
      .wrptr    (wrptr[c]),
      .rdptr    (rdptr[c]),
      .len      (len[c]),
      .hwm      (hwm[c]),
      .notempty (notempty[c]),
      .full     (full[c]),
      .afull    (afull[c]),
      .ovf      (ovf[c]),
      .udf      (udf[c])
    );
  end

  always_comb begin
    wsel    = '0;
    rsel    = '0;
    qry_len = '0;
    qry_hwm = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ch == CHBIT'(i)) wsel = wrptr[i];
      if (rd_ch == CHBIT'(i)) rsel = rdptr[i];
      if (qry_ch == CHBIT'(i)) begin
        qry_len = len[i];
        qry_hwm = hwm[i];
      end
    end
  end

  assign mem_we = |wr_acc;
  assign mem_re = |rd_acc;
  assign mem_wa = MEMABIT'(ch_base(int'(wr_ch), LENGTH) + int'(wsel));
  assign mem_ra = MEMABIT'(ch_base(int'(rd_ch), LENGTH) + int'(rsel));
endmodule

// File: tb/tb_fifoc_anylen_mch.sv
// Two instances (LENGTH 16 and 12) driven in lockstep and checked against a behavioural model.
module tb_fifoc_anylen_mch;
  localparam int NCH = 4;
  localparam int LENS [2] = '{16, 12};
  localparam int AFT  [2] = '{12, 9};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, rd_en, fsh_en;
  logic [1:0] wr_ch, rd_ch, fsh_ch, qry_ch;
  logic [4:0] qry_len [2];
  logic [4:0] qry_hwm [2];
  logic [3:0] notempty [2];
  logic [3:0] full [2];
  logic [3:0] afull [2];
  logic [3:0] ovf [2];
  logic [3:0] udf [2];
  logic       mem_we [2];
  logic       mem_re [2];
  logic [5:0] mem_wa [2];
  logic [5:0] mem_ra [2];

  fifoc_anylen_mch #(.NCH(4), .CHBIT(2), .LENGTH(16), .ADDRBIT(4), .MEMABIT(6), .AFTHR(12)) u_dut16 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .rd_en(rd_en), .rd_ch(rd_ch),
    .fsh_en(fsh_en), .fsh_ch(fsh_ch), .qry_ch(qry_ch), .qry_len(qry_len[0]), .qry_hwm(qry_hwm[0]),
    .notempty(notempty[0]), .full(full[0]), .afull(afull[0]), .ovf(ovf[0]), .udf(udf[0]),
    .mem_we(mem_we[0]), .mem_wa(mem_wa[0]), .mem_re(mem_re[0]), .mem_ra(mem_ra[0]));

  fifoc_anylen_mch #(.NCH(4), .CHBIT(2), .LENGTH(12), .ADDRBIT(4), .MEMABIT(6), .AFTHR(9)) u_dut12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .rd_en(rd_en), .rd_ch(rd_ch),
    .fsh_en(fsh_en), .fsh_ch(fsh_ch), .qry_ch(qry_ch), .qry_len(qry_len[1]), .qry_hwm(qry_hwm[1]),
    .notempty(notempty[1]), .full(full[1]), .afull(afull[1]), .ovf(ovf[1]), .udf(udf[1]),
    .mem_we(mem_we[1]), .mem_wa(mem_wa[1]), .mem_re(mem_re[1]), .mem_ra(mem_ra[1]));

  typedef struct {
    bit we;
    int wa;
    bit re;
    int ra;
  } mexp_t;

  mexp_t sb [$];
  int m_len [2][NCH];
  int m_wp  [2][NCH];
  int m_rp  [2][NCH];
  int m_hwm [2][NCH];
  bit m_ovf [2][NCH];
  bit m_udf [2][NCH];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_status(input int qc);
    logic [3:0] e_ne, e_fu, e_af, e_ov, e_ud;
    int e_hwm;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NCH; c++) begin
        e_ne[c] = (m_len[d][c] != 0);
        e_fu[c] = (m_len[d][c] == LENS[d]);
        e_af[c] = (m_len[d][c] >= AFT[d]);
        e_ov[c] = m_ovf[d][c];
        e_ud[c] = m_udf[d][c];
      end
`ifdef FIFOC_HWM_EN
      e_hwm = m_hwm[d][qc];
`else
      e_hwm = 0;
`endif
      check($sformatf("L%0d notempty", LENS[d]), notempty[d], int'(e_ne));
      check($sformatf("L%0d full", LENS[d]), full[d], int'(e_fu));
      check($sformatf("L%0d afull", LENS[d]), afull[d], int'(e_af));
      check($sformatf("L%0d ovf", LENS[d]), ovf[d], int'(e_ov));
      check($sformatf("L%0d udf", LENS[d]), udf[d], int'(e_ud));
      check($sformatf("L%0d qry_len[%0d]", LENS[d], qc), qry_len[d], m_len[d][qc]);
      check($sformatf("L%0d qry_hwm[%0d]", LENS[d], qc), qry_hwm[d], e_hwm);
    end
  endtask

  // One clock of stimulus: model predicts strobes, then state after the edge.
  task automatic cyc(input bit we, input int wc, input bit re, input int rc,
                     input bit fe, input int fc, input int qc);
    mexp_t e;
    bit    fh, isfull, isempty, wacc, racc;
    int    nl;
    @(negedge clk);
    wr_en = we;  wr_ch  = 2'(wc);
    rd_en = re;  rd_ch  = 2'(rc);
    fsh_en = fe; fsh_ch = 2'(fc);
    qry_ch = 2'(qc);
    for (int d = 0; d < 2; d++) begin
      e = '{we: 1'b0, wa: 0, re: 1'b0, ra: 0};
      for (int c = 0; c < NCH; c++) begin
        fh      = fe && (fc == c);
        isfull  = (m_len[d][c] == LENS[d]);
        isempty = (m_len[d][c] == 0);
        wacc    = we && (wc == c) && !isfull && !fh;
        racc    = re && (rc == c) && !isempty && !fh;
        if (wacc) begin e.we = 1'b1; e.wa = c * LENS[d] + m_wp[d][c]; end
        if (racc) begin e.re = 1'b1; e.ra = c * LENS[d] + m_rp[d][c]; end
        if (fh) begin
          m_len[d][c] = 0; m_wp[d][c] = 0; m_rp[d][c] = 0;
          m_hwm[d][c] = 0; m_ovf[d][c] = 1'b0; m_udf[d][c] = 1'b0;
        end else begin
          nl = m_len[d][c] + (wacc ? 1 : 0) - (racc ? 1 : 0);
          if (wacc) m_wp[d][c] = (m_wp[d][c] == LENS[d] - 1) ? 0 : m_wp[d][c] + 1;
          if (racc) m_rp[d][c] = (m_rp[d][c] == LENS[d] - 1) ? 0 : m_rp[d][c] + 1;
          if (we && (wc == c) && isfull)  m_ovf[d][c] = 1'b1;
          if (re && (rc == c) && isempty) m_udf[d][c] = 1'b1;
          m_len[d][c] = nl;
          if (nl > m_hwm[d][c]) m_hwm[d][c] = nl;
        end
      end
      sb.push_back(e);
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      e = sb.pop_front();
      check($sformatf("L%0d mem_we", LENS[d]), mem_we[d], int'(e.we));
      if (e.we) check($sformatf("L%0d mem_wa", LENS[d]), mem_wa[d], e.wa);
      check($sformatf("L%0d mem_re", LENS[d]), mem_re[d], int'(e.re));
      if (e.re) check($sformatf("L%0d mem_ra", LENS[d]), mem_ra[d], e.ra);
    end
    @(posedge clk);
    #1;
    check_status(qc);
  endtask

  task automatic wr(input int c, input int n);
    repeat (n) cyc(1'b1, c, 1'b0, 0, 1'b0, 0, c);
  endtask

  task automatic rd(input int c, input int n);
    repeat (n) cyc(1'b0, 0, 1'b1, c, 1'b0, 0, c);
  endtask

  task automatic flush(input int c);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, c, c);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; fsh_en = 1'b0;
    wr_ch = '0; rd_ch = '0; fsh_ch = '0; qry_ch = 2'd1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_len[d][c] = 0; m_wp[d][c] = 0; m_rp[d][c] = 0;
        m_hwm[d][c] = 0; m_ovf[d][c] = 1'b0; m_udf[d][c] = 1'b0;
      end
    repeat (2) @(posedge clk);
    #1;
    check_status(1);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("L%0d reset mem_we", LENS[d]), mem_we[d], 0);
      check($sformatf("L%0d reset mem_re", LENS[d]), mem_re[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    wr(1, 17);                                   // fill ch1, then overflow attempt
    repeat (2) begin wr(0, 12); rd(0, 12); end   // pointer wrap on ch0
    wr(2, 16);
    cyc(1'b1, 2, 1'b1, 2, 1'b0, 0, 2);           // rd+wr while full
    rd(2, 10);
    cyc(1'b1, 2, 1'b1, 2, 1'b0, 0, 2);           // rd+wr at len 5
    rd(3, 1);                                    // underflow
    flush(3);
    wr(0, 7);
    cyc(1'b1, 0, 1'b1, 1, 1'b1, 0, 0);           // flush beats write, other read proceeds
    flush(1);
    wr(1, 9); rd(1, 4); wr(1, 2);
    flush(1);

    for (int i = 0; i < 250; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 9) < 3,
          $urandom_range(0, 3), $urandom_range(0, 19) == 0, $urandom_range(0, 3),
          $urandom_range(0, 3));
    for (int i = 0; i < 250; i++)
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 9) < 7,
          $urandom_range(0, 3), $urandom_range(0, 19) == 0, $urandom_range(0, 3),
          $urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
